gj_axis_uart_tx_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single AXI-Stream TX port of the UART core among NPORT byte-stream requesters. A grant is held from a packet's first beat until its `tlast` beat, so frames from different sources never interleave on the wire. A programmable idle gap between packets lets the receiver's max-gap frame detection separate packets. The block sits directly in front of the UART core's `tx_t*` input.

---
 rtl/gj_axis_uart_pkg.sv | 16 +
 rtl/gj_rr_pick.sv | 32 +++
 rtl/gj_axis_uart_tx_arb.sv | 113 +++++++++++
 tb/tb_gj_axis_uart_tx_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gj_axis_uart_pkg.sv
// Shared types and defaults for the UART TX stream arbiter.
//   arb_state_t : arbiter FSM states (IDLE, XFER, GAP)
//   DEF_*       : default parameter values for the arbiter and its helpers
package gj_axis_uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NPORT = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_GAPW  = 16;

endpackage

// File: rtl/gj_rr_pick.sv
// Combinational rotate-priority pick.
//   req : request vector, one bit per port
//   ptr : port with highest priority this cycle (search wraps past NPORT-1)
//   any : at least one request present
//   idx : first requesting port at or after ptr, cyclically; 0 when none
module gj_rr_pick
    import gj_axis_uart_pkg::*;
#(
    parameter  int NPORT = DEF_NPORT,
    localparam int IW    = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] pos;

    // Walk from the farthest candidate back to ptr so the closest
    // requester overwrites the others and wins.
    always_comb begin
        any = |req;
        idx = '0;
        pos = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr) + k) % NPORT);
            if (req[pos]) idx = pos;
        end
    end

endmodule

// File: rtl/gj_axis_uart_tx_arb.sv
// Packet-granular round-robin arbiter in front of the UART TX stream.
// A grant is held from first beat to tlast; an optional idle gap follows
// every packet so the receiver can find frame boundaries.
//   clk, rst          : clock, async active-low reset
//   s_tvalid/tready/tdata/tlast : NPORT source streams (port i at [i*DW +: DW])
//   m_tvalid/tready/tdata/tlast : single stream to the UART TX
//   cfg_gap           : idle cycles after each packet (sampled at tlast)
//   cfg_en            : per-port enable, gates new grants only
//   grant_id          : current or last granted port
//   busy              : high in XFER and GAP
//   sts_pkts          : forwarded packet count, wraps
module gj_axis_uart_tx_arb
    import gj_axis_uart_pkg::*;
#(
    parameter  int NPORT = DEF_NPORT,
    parameter  int DW    = DEF_DW,
    parameter  int GAPW  = DEF_GAPW,
    localparam int IW    = $clog2(NPORT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    s_tvalid,
    output logic [NPORT-1:0]    s_tready,
    input  logic [NPORT*DW-1:0] s_tdata,
    input  logic [NPORT-1:0]    s_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [DW-1:0]       m_tdata,
    output logic                m_tlast,
    input  logic [GAPW-1:0]     cfg_gap,
    input  logic [NPORT-1:0]    cfg_en,
    output logic [IW-1:0]       grant_id,
    output logic                busy,
    output logic [15:0]         sts_pkts
);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] ptr;
    logic [GAPW-1:0] cnt;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          last_hs;
    logic [DW-1:0] lane [NPORT];

    for (genvar i = 0; i < NPORT; i++) begin : g_lane
        assign lane[i] = s_tdata[i*DW +: DW];
    end

    gj_rr_pick #(.NPORT(NPORT)) u_pick (
        .req (s_tvalid & cfg_en),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Final beat of the granted packet is accepted this cycle.
    assign last_hs = (state == XFER) & s_tvalid[grant_id] & s_tlast[grant_id] & m_tready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_any) state_nxt = XFER;
            XFER:    if (last_hs)  state_nxt = (cfg_gap != '0) ? GAP : IDLE;
            GAP:     if (cnt == GAPW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: pure pass-through of the granted port while in XFER
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (state == XFER) begin
            m_tvalid           = s_tvalid[grant_id];
            m_tdata            = lane[grant_id];
            m_tlast            = s_tlast[grant_id];
            s_tready[grant_id] = m_tready;
        end
    end

    assign busy = (state != IDLE);

    // Grant, rotation pointer, gap counter and packet counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            grant_id <= '0;
            cnt      <= '0;
            sts_pkts <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant_id <= pick_idx;
                ptr      <= (pick_idx == IW'(NPORT - 1)) ? '0 : pick_idx + IW'(1);
            end
            if (last_hs) begin
                sts_pkts <= sts_pkts + 16'd1;
                cnt      <= cfg_gap;
            end else if (state == GAP) begin
                cnt <= cnt - GAPW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gj_axis_uart_tx_arb.sv
module tb_gj_axis_uart_tx_arb;

    localparam int NPORT = 4;
    localparam int DW    = 8;
    localparam int GAPW  = 16;
    localparam int IW    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NPORT-1:0]    s_tvalid, s_tready, s_tlast, cfg_en;
    logic [NPORT*DW-1:0] s_tdata;
    logic                m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]       m_tdata;
    logic [GAPW-1:0]     cfg_gap;
    logic [IW-1:0]       grant_id;
    logic                busy;
    logic [15:0]         sts_pkts;

    gj_axis_uart_tx_arb #(.NPORT(NPORT), .DW(DW), .GAPW(GAPW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .cfg_gap(cfg_gap), .cfg_en(cfg_en), .grant_id(grant_id), .busy(busy), .sts_pkts(sts_pkts)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            if (err < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_byte(input int p, input int s);
        return DW'(p * 32 + (s % 32));
    endfunction

    // ---------------- behavioural reference ----------------
    // owner: port currently holding the wire (-1 none); gap: idle cycles still owed
    int mo_owner = -1, mo_last = 0, mo_start = 0, mo_gap = 0, mo_pkts = 0;

    function automatic int rr_pick(input logic [NPORT-1:0] req, input int start);
        for (int k = 0; k < NPORT; k++) begin
            int p = (start + k) % NPORT;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mo_owner <= -1; mo_last <= 0; mo_start <= 0; mo_gap <= 0; mo_pkts <= 0;
        end else if (mo_owner >= 0) begin
            if (s_tvalid[mo_owner[IW-1:0]] && m_tready && s_tlast[mo_owner[IW-1:0]]) begin
                mo_pkts  <= (mo_pkts + 1) % 65536;
                mo_owner <= -1;
                mo_gap   <= int'(cfg_gap);
            end
        end else if (mo_gap > 0) begin
            mo_gap <= mo_gap - 1;
        end else if (rr_pick(s_tvalid & cfg_en, mo_start) >= 0) begin
            mo_owner <= rr_pick(s_tvalid & cfg_en, mo_start);
            mo_last  <= rr_pick(s_tvalid & cfg_en, mo_start);
            mo_start <= (rr_pick(s_tvalid & cfg_en, mo_start) + 1) % NPORT;
        end
    end

    task automatic check_cycle();
        logic ev, el;
        logic [DW-1:0] ed;
        logic [NPORT-1:0] er;
        ev = 1'b0; el = 1'b0; ed = '0; er = '0;
        if (mo_owner >= 0) begin
            ev = s_tvalid[mo_owner[IW-1:0]];
            el = s_tlast[mo_owner[IW-1:0]];
            ed = s_tdata[mo_owner*DW +: DW];
            er[mo_owner[IW-1:0]] = m_tready;
        end
        chk("m_tvalid", m_tvalid, ev);
        chk("m_tlast",  m_tlast,  el);
        chk("m_tdata",  m_tdata,  ed);
        chk("s_tready", s_tready, er);
        chk("busy",     busy,     (mo_owner >= 0 || mo_gap > 0));
        chk("grant_id", grant_id, mo_last);
        chk("sts_pkts", sts_pkts, mo_pkts);
    endtask

    always @(negedge clk) check_cycle();

    // ---------------- sources / sink drive ----------------
    int plen[NPORT], pbeat[NPORT], left[NPORT], fixlen[NPORT], seq[NPORT], rx_seq[NPORT];
    int vprob = 100, rmode = 0;
    logic tog = 1'b0;
    logic [NPORT-1:0] hs_src = '0;

    // snapshot of the settled pre-edge values used by the edge monitor
    logic [NPORT-1:0] sn_sv, sn_sr;
    logic sn_mv, sn_mr, sn_ml, sn_busy;
    logic [DW-1:0] sn_md;
    logic [IW-1:0] sn_gid;

    task automatic snap();
        sn_sv = s_tvalid; sn_sr = s_tready; sn_mv = m_tvalid; sn_mr = m_tready;
        sn_ml = m_tlast; sn_md = m_tdata; sn_gid = grant_id; sn_busy = busy;
    endtask

    task automatic drive();
        for (int i = 0; i < NPORT; i++) begin
            if (hs_src[i]) begin
                seq[i]++;
                pbeat[i]++;
                if (pbeat[i] == plen[i]) plen[i] = 0;
            end
            if (plen[i] == 0 && left[i] != 0) begin
                plen[i]  = (fixlen[i] > 0) ? fixlen[i] : int'($urandom_range(1, 6));
                pbeat[i] = 0;
                if (left[i] > 0) left[i]--;
            end
            s_tvalid[i] = (plen[i] != 0) && (($urandom % 100) < vprob);
            s_tlast[i]  = (plen[i] != 0) && (pbeat[i] == plen[i] - 1);
            s_tdata[i*DW +: DW] = exp_byte(i, seq[i]);
        end
        hs_src = '0;
        case (rmode)
            0:       m_tready = 1'b1;
            1:       begin tog = ~tog; m_tready = tog; end
            default: m_tready = 1'($urandom % 2);
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        #1 drive();
        #1 snap();
    endtask

    // ---------------- edge monitor / scoreboard ----------------
    int order[$];
    int beats = 0, tlasts = 0, last_len = 0, pkt_len = 0, pkt_port = 0;
    int ecnt = 0, t_last = 0, blo = 0, meas_idle = -1, meas_blo = -1;
    bit in_pkt = 0;

    initial forever begin
        @(posedge clk);
        hs_src = sn_sv & sn_sr;
        if (!sn_busy) blo++;
        if (sn_mv && sn_mr) begin
            if (!in_pkt) begin
                order.push_back(int'(sn_gid));
                meas_idle = ecnt - t_last - 1;
                meas_blo  = blo;
                pkt_port  = int'(sn_gid);
                pkt_len   = 0;
            end else begin
                chk("no_interleave", sn_gid, pkt_port);
            end
            chk("data_order", sn_md, exp_byte(int'(sn_gid), rx_seq[sn_gid]));
            rx_seq[sn_gid]++;
            beats++;
            pkt_len++;
            if (sn_ml) begin
                in_pkt = 0; tlasts++; last_len = pkt_len; t_last = ecnt; blo = 0;
            end else begin
                in_pkt = 1;
            end
        end
        ecnt++;
    end

    task automatic set_src(input int i, input int npk, input int len);
        left[i] = npk; fixlen[i] = len;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            plen[i] = 0; pbeat[i] = 0; left[i] = 0; fixlen[i] = 0;
        end
        hs_src = '0; in_pkt = 0;
        vprob = 100; rmode = 0; cfg_gap = '0; cfg_en = '1;
        #1 snap();
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        bit done = 0;
        while (!done && n < max) begin
            step();
            n++;
            done = !sn_busy;
            for (int i = 0; i < NPORT; i++) if (plen[i] != 0 || left[i] != 0) done = 0;
        end
        chk("idle_reached", done, 1);
    endtask

    task automatic wait_beats(input int n, input int b0);
        int k = 0;
        while (beats - b0 < n && k < 200) begin step(); k++; end
        chk("beats_reached", (beats - b0 >= n), 1);
    endtask

    initial begin
        int b0, s1, sum0, sum1;
        int rr_exp[6];
        rr_exp = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < NPORT; i++) begin
            plen[i] = 0; pbeat[i] = 0; left[i] = 0; fixlen[i] = 0; seq[i] = 0; rx_seq[i] = 0;
        end
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        cfg_gap = '0; cfg_en = '1;

        // reset state
        step(); step();
        chk("rst_busy",     busy,     0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_sts_pkts", sts_pkts, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);

        // single port, 10 beats
        do_reset();
        b0 = beats;
        set_src(0, 1, 10);
        run_idle(400);
        chk("single_beats", beats - b0, 10);
        chk("single_len",   last_len,   10);
        chk("single_pkts",  sts_pkts,   1);
        chk("single_gid",   grant_id,   0);

        // round robin over 0,1,3
        do_reset();
        order.delete();
        set_src(0, 2, 4); set_src(1, 2, 4); set_src(3, 2, 4);
        run_idle(400);
        chk("rr_count", order.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < order.size()) chk($sformatf("rr_grant%0d", k), order[k], rr_exp[k]);
        chk("gap0_idle", meas_idle, 1);

        // inter-packet gap
        do_reset();
        cfg_gap = 16'd3;
        set_src(2, 2, 3);
        run_idle(400);
        chk("gap_idle",    meas_idle, 4);
        chk("gap_busy_lo", meas_blo,  1);
        chk("gap_pkts",    sts_pkts,  2);

        // backpressure
        do_reset();
        rmode = 1; tog = 1'b0;
        b0 = beats;
        set_src(1, 1, 6);
        run_idle(400);
        chk("bp_beats", beats - b0, 6);
        chk("bp_len",   last_len,   6);

        // enable mask
        do_reset();
        cfg_en = 4'b0001;
        b0 = beats; s1 = seq[1];
        set_src(0, 1, 6); set_src(1, 1, 4);
        wait_beats(2, b0);
        cfg_en = '0;
        repeat (30) step();
        chk("en_pkts",    sts_pkts,   1);
        chk("en_busy",    sn_busy,    0);
        chk("en_gid",     grant_id,   0);
        chk("en_len",     last_len,   6);
        chk("en_p1_held", seq[1] - s1, 0);
        cfg_en = '1;
        run_idle(400);
        chk("en_p1_late", sts_pkts, 2);

        // reset mid-packet
        do_reset();
        order.delete();
        b0 = beats;
        set_src(0, 1, 1); set_src(2, 1, 8);
        wait_beats(4, b0);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_m_tvalid", m_tvalid, 0);
        chk("rstmid_m_tlast",  m_tlast,  0);
        chk("rstmid_s_tready", s_tready, 0);
        chk("rstmid_busy",     busy,     0);
        chk("rstmid_sts_pkts", sts_pkts, 0);
        snap(); hs_src = '0; in_pkt = 0;
        order.delete();
        set_src(1, 1, 2); set_src(3, 1, 2);
        step(); step();
        rst = 1'b1;
        run_idle(400);
        chk("rstmid_order_n", order.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < order.size()) chk($sformatf("rstmid_grant%0d", k), order[k], k + 1);
        chk("rstmid_pkts", sts_pkts, 3);

        // randomized traffic
        do_reset();
        rmode = 2; vprob = 70;
        b0 = beats;
        sum0 = 0;
        for (int i = 0; i < NPORT; i++) begin sum0 += seq[i]; left[i] = -1; fixlen[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 97 == 0)  cfg_gap = GAPW'($urandom_range(0, 4));
            if (c % 211 == 0) cfg_en = NPORT'($urandom_range(1, 15));
        end
        for (int i = 0; i < NPORT; i++) left[i] = 0;
        cfg_en = '1;
        run_idle(3000);
        sum1 = 0;
        for (int i = 0; i < NPORT; i++) sum1 += seq[i];
        chk("rand_beats", beats - b0, sum1 - sum0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
